inst_fetch: RTL
===============

// Module: inst_fetch
// PURPOSE
//  IF-stage fetch unit: drives if_pc/if_inst/if_valid into the IF/ID pipeline register.
//  Owns the PC and a single-outstanding req/gnt/rvalid handshake to instruction memory.
//  Holds one fetched instruction in an output buffer across stalls.
//  Squashes wrong-path fetches on flush or branch redirect.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC of first fetch after reset
//  PC_INC    4              byte increment per sequential fetch
// PORTS
//  clk            in   1   clock, all state on posedge
//  rst            in   1   reset, synchronous, active-high
//  stall          in   1   hazard unit: IF/ID not accepting; hold output buffer
//  flush          in   1   exception/pipeline flush; redirect to flush_pc
//  flush_pc       in   32  flush target
//  branch_flag    in   1   branch/jump resolved taken; redirect to branch_target
//  branch_target  in   32  branch target
//  imem_req       out  1   fetch request, valid with imem_addr
//  imem_addr      out  32  fetch address
//  imem_gnt       in   1   request accepted this cycle
//  imem_rvalid    in   1   read data valid; >=1 cycle after gnt, exactly one per gnt
//  imem_rdata     in   32  instruction word
//  if_pc          out  32  PC of buffered instruction, 32'h0 when !if_valid
//  if_inst        out  32  buffered instruction, 32'h0 (NOP) when !if_valid
//  if_valid       out  1   output buffer holds a valid instruction
// BEHAVIOUR
//  Reset (rst=1 at posedge): pc<=RESET_PC, state<=FETCH, buf_valid<=0, drop<=0.
//  - During a reset cycle imem_req=0.
//  - After reset: if_valid=0, if_pc=if_inst=0.
//  State: pc, state{FETCH,WAIT}, drop, buf_valid/buf_pc/buf_inst, inflight_pc.
//  consume = buf_valid & !stall; redirect = flush | branch_flag; flush has priority.
//  Redirect target: flush_pc if flush, else branch_target.
//  FETCH:
//  - imem_req = !rst & (!buf_valid | consume) & !redirect; imem_addr = pc.
//  - req & gnt -> inflight_pc<=pc, pc<=pc+PC_INC (mod 2^32), state<=WAIT, drop<=0.
//  WAIT:
//  - imem_req=0.
//  - On rvalid with !drop & !redirect: buf_valid<=1, buf_pc<=inflight_pc,
//    buf_inst<=imem_rdata; state<=FETCH.
//  - On rvalid with drop|redirect: discard data; state<=FETCH; drop<=0.
//  Redirect (any state, any cycle):
//  - pc<=target; buf_valid<=0.
//  - If state==WAIT and no rvalid this cycle: drop<=1 (response still pending).
//  - The redirect-cycle fetch is suppressed (imem_req=0), so no request is granted
//    with the stale pc.
//  Buffer:
//  - No redirect and no fill: consume -> buf_valid<=0.
//  - Stall with buf_valid -> buffer unchanged; if_* held.
//  - A new request issues only when the buffer is empty or consumed this cycle, so an
//    rvalid never meets a full, stalled buffer. Nothing to arbitrate.
//  Outputs are registered, driven from the buffer only.
//  - Latency: gnt at cycle t, rvalid at t+k (k>=1), if_valid high from t+k+1.
//  - Peak throughput: one instruction per 2 cycles with k=1.
//  Stall and redirect in the same cycle: redirect wins; buffer cleared.
//  Reset mid-WAIT: state<=FETCH, drop<=0. A late rvalid arriving in FETCH is ignored.
// TESTING
//  1 rst 2 cyc, gnt=1 always, rvalid 1 cyc after gnt, rdata=addr^32'hA5A5A5A5 -> first
//    imem_addr=0; if_pc 0,4,8 with matching if_inst; if_valid high every other cycle.
//  2 stall=1 for 5 cyc while if_valid=1 at if_pc=8 -> if_pc/if_inst held 5 cyc;
//    imem_req=0; next fetch addr=12 issued in the cycle stall drops.
//  3 branch_flag=1, branch_target=32'h100 while WAIT on addr 16 -> rvalid for 16
//    discarded; next imem_addr=32'h100; if_pc=32'h100 next valid output.
//  4 flush=1, flush_pc=32'h80 and branch_flag=1 same cycle -> pc=32'h80;
//    if_valid=0 next cycle; next fetch addr 32'h80.
//  5 gnt held low 10 cyc, rvalid latency 3 -> imem_req/imem_addr stable while waiting;
//    no PC skip; no duplicate requests.
//  6 rst=1 asserted in WAIT, rvalid arrives during/after reset -> data ignored; if_valid=0;
//    first fetch after reset at RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// IF-stage fetch unit: owns the PC, issues one outstanding imem request at a time and
// holds the fetched instruction in a registered output buffer for the IF/ID register.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_INC   = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        branch_flag,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_valid
);

   typedef enum logic [0:0] {FETCH = 1'b0, WAIT = 1'b1} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic        buf_valid_q, buf_valid_d;
   logic        drop_q, drop_d;
   logic        consume_s, redirect_s, fill_s;
   logic [31:0] target_s;

   // Handshake qualifiers and the request, which must be suppressed in the redirect cycle
   always_comb begin
      consume_s  = buf_valid_q & ~stall;
      redirect_s = flush | branch_flag;
      target_s   = flush ? flush_pc : branch_target;
      imem_req   = ~rst & (state_q == FETCH) & (~buf_valid_q | consume_s) & ~redirect_s;
      imem_addr  = pc_q;
   end

   // Next-state logic: fetch sequencing, buffer fill/consume, redirect squash
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inflight_pc_d = inflight_pc_q;
      buf_pc_d      = buf_pc_q;
      buf_inst_d    = buf_inst_q;
      buf_valid_d   = buf_valid_q;
      drop_d        = drop_q;
      fill_s        = 1'b0;

      case (state_q)
         FETCH: begin
            if (imem_req && imem_gnt) begin
               inflight_pc_d = pc_q;
               pc_d          = pc_q + PC_INC;
               state_d       = WAIT;
               drop_d        = 1'b0;
            end else begin
               state_d = FETCH;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_d = FETCH;
               drop_d  = 1'b0;
               fill_s  = ~drop_q & ~redirect_s;
            end else begin
               state_d = WAIT;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase

      // Buffer fields are zeroed whenever empty so the outputs read as NOP directly
      if (fill_s) begin
         buf_valid_d = 1'b1;
         buf_pc_d    = inflight_pc_q;
         buf_inst_d  = imem_rdata;
      end else if (consume_s) begin
         buf_valid_d = 1'b0;
         buf_pc_d    = 32'h0;
         buf_inst_d  = 32'h0;
      end else begin
         buf_valid_d = buf_valid_q;
      end

      if (redirect_s) begin
         pc_d        = target_s;
         buf_valid_d = 1'b0;
         buf_pc_d    = 32'h0;
         buf_inst_d  = 32'h0;
         // A response still owed for the squashed fetch must be swallowed when it lands
         if (state_q == WAIT && !imem_rvalid) begin
            drop_d = 1'b1;
         end else begin
            drop_d = drop_d;
         end
      end else begin
         pc_d = pc_d;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         inflight_pc_q <= 32'h0;
         buf_pc_q      <= 32'h0;
         buf_inst_q    <= 32'h0;
         buf_valid_q   <= 1'b0;
         drop_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_pc_q <= inflight_pc_d;
         buf_pc_q      <= buf_pc_d;
         buf_inst_q    <= buf_inst_d;
         buf_valid_q   <= buf_valid_d;
         drop_q        <= drop_d;
      end
   end

   assign if_valid = buf_valid_q;
   assign if_pc    = buf_pc_q;
   assign if_inst  = buf_inst_q;

endmodule
